// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control on both sides.
// Defining PCLA_SAT_EN adds the sat port and signed saturation of sum.
module pipelined_cla_adder #(
  parameter int WIDTH   = 32,
  parameter int GROUP   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PCLA_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             Gm,
  output logic             Pm
);

  localparam int NG = WIDTH / GROUP;
  localparam int NB = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    pg;
    logic             ci;
    logic             sat;
    logic             amsb;
  } front_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             gm;
    logic             pm;
  } back_t;

  // Bit generate/propagate and first lookahead level (per-group G/P).
  function automatic front_t stage1_calc(input logic vld, input logic [WIDTH-1:0] av,
                                         input logic [WIDTH-1:0] bv, input logic ci_in,
                                         input logic sb, input logic st);
    front_t f;
    logic [WIDTH-1:0] bx;
    logic gacc;
    logic pacc;
    f = '0;
    bx = sb ? ~bv : bv;
    f.valid = vld;
    f.g = av & bx;
    f.p = av ^ bx;
    f.ci = ci_in ^ sb;
    f.sat = st;
    f.amsb = av[WIDTH-1];
    for (int k = 0; k < NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gacc = f.g[k*GROUP+j] | (f.p[k*GROUP+j] & gacc);
        pacc = pacc & f.p[k*GROUP+j];
      end
      f.gg[k] = gacc;
      f.pg[k] = pacc;
    end
    return f;
  endfunction

  // Second lookahead level: group carries, bit carries, sum and flags.
  function automatic back_t stage2_calc(input front_t f);
    back_t r;
    logic [NG:0] cg;
    logic [WIDTH-1:0] cb;
    logic carry;
    r = '0;
    cg = '0;
    cb = '0;
    cg[0] = f.ci;
    r.gm = 1'b0;
    r.pm = 1'b1;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = f.gg[k] | (f.pg[k] & cg[k]);
      r.gm = f.gg[k] | (f.pg[k] & r.gm);
      r.pm = r.pm & f.pg[k];
    end
    for (int k = 0; k < NG; k++) begin
      carry = cg[k];
      for (int j = 0; j < GROUP; j++) begin
        cb[k*GROUP+j] = carry;
        carry = f.g[k*GROUP+j] | (f.p[k*GROUP+j] & carry);
      end
    end
    r.valid = f.valid;
    r.sum = f.p ^ cb;
    r.cout = cg[NG];
    r.ovf = cb[WIDTH-1] ^ cg[NG];
`ifdef PCLA_SAT_EN
    // Clamp only the sum; the flags keep reporting the raw result.
    if (f.sat && r.ovf) begin
      r.sum = f.amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r.sum = f.p ^ cb;
    end
`endif
    return r;
  endfunction

  logic   adv_s;
  logic   sat_s;
  front_t front_s;
  back_t  back_in_s;
  back_t  back_r [NB];

`ifdef PCLA_SAT_EN
  assign sat_s = sat;
`else
  assign sat_s = 1'b0;
`endif

  assign adv_s    = out_ready | ~back_r[NB-1].valid;
  assign in_ready = adv_s;
  assign front_s  = stage1_calc(in_valid, a, b, cin, sub, sat_s);

  generate
    if (LATENCY > 1) begin : g_front
      front_t front_r;

      // Stage 1 register: group G/P, bit g/p and effective carry-in.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          front_r <= '0;
        end else if (adv_s) begin
          front_r <= front_s;
        end
      end

      assign back_in_s = stage2_calc(front_r);
    end else begin : g_nofront
      assign back_in_s = stage2_calc(front_s);
    end
  endgenerate

  // Result register followed by pure re-timing stages; all shift together on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        back_r[i] <= '0;
      end
    end else if (adv_s) begin
      back_r[0] <= back_in_s;
      for (int i = 1; i < NB; i++) begin
        back_r[i] <= back_r[i-1];
      end
    end
  end

  assign out_valid = back_r[NB-1].valid;
  assign sum       = back_r[NB-1].sum;
  assign cout      = back_r[NB-1].cout;
  assign ovf       = back_r[NB-1].ovf;
  assign Gm        = back_r[NB-1].gm;
  assign Pm        = back_r[NB-1].pm;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4, LATENCY=2).
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
`ifdef PCLA_SAT_EN
  logic        sat;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        Gm;
  logic        Pm;

  int checks = 0;
  int errors = 0;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PCLA_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .Gm(Gm), .Pm(Pm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = ci;
    sub = sb;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input logic [15:0] esum,
                         input logic ecout, input logic eovf, input logic egm, input logic epm);
    drive(av, bv, ci, sb);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({tag, "_gm"}, {31'd0, Gm}, {31'd0, egm});
    chk({tag, "_pm"}, {31'd0, Pm}, {31'd0, epm});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
`ifdef PCLA_SAT_EN
    sat = 1'b0;
`endif
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_flags", {27'd0, cout, ovf, Gm, Pm, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_vec("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub_bin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("prop", 16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0);
    run_vec("plain", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PCLA_SAT_EN
    sat = 1'b1;
    run_vec("sat_max", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec("sat_min", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
    sat = 1'b0;
`endif
    @(posedge clk); #1;

    // Back-to-back bundles with a three-cycle output stall.
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_lat", {31'd0, out_valid}, 32'd0);
    drive(16'h0002, 16'h0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_first_sum", {16'd0, sum}, 32'h0002);
    drive(16'h0003, 16'h0003, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sum", {16'd0, sum}, 32'h0002);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_sum4", {16'd0, sum}, 32'h0004);
    chk("b2b_valid4", {31'd0, out_valid}, 32'd1);
    drive(16'h0004, 16'h0004, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_sum6", {16'd0, sum}, 32'h0006);
    chk("b2b_valid6", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_sum8", {16'd0, sum}, 32'h0008);
    chk("b2b_valid8", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Reset with two bundles in flight.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_cout", {31'd0, cout}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_flags", {28'd0, cout, ovf, Gm, Pm}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
